dispatch_window: RTL and testbench
==================================

Name: dispatch_window

Overview:
- Parametrised successor to the combinational superscalar pre-decode/arrange stage.
- Buffers fetched instruction groups in a circular queue and classifies each entry (ALU, branch, load, store).
- Each cycle, issues the longest in-order prefix from the queue head into typed execution slots: NUM_ALU ALU/branch slots, one load slot, one store slot.
- Sits between fetch and the register-read stage. Resolves slot conflicts, intra-group RAW/WAW and load-use hazards itself, tracking the previous load internally instead of taking a prv_ld input.

Parameters:
- FETCH_W, 4, instructions pushed per fetch beat (1..8).
- DEPTH, 8, queue entries; power of two, >= FETCH_W.
- NUM_ALU, 2, ALU/branch issue slots (1..4); total slots NSLOT = NUM_ALU+2.
- MAX_ISSUE, 4, maximum instructions issued per cycle (<= NSLOT).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- fetch_valid  in  1  fetch group present.
- fetch_instr  in  32*FETCH_W  group; lane 0 is oldest, in bits [31:0].
- fetch_pc  in  32  PC of lane 0; lane i PC = fetch_pc+4*i.
- fetch_ready  out  1  queue can accept a whole group.
- flush  in  1  branch redirect; discard all queued and issuing work.
- exec_stall  in  1  downstream stall; hold issue outputs.
- issue_valid  out  NSLOT  per-slot valid. Slots 0..NUM_ALU-1 are ALU/branch, slot NUM_ALU is load, slot NUM_ALU+1 is store.
- issue_instr  out  32*NSLOT  per-slot instruction.
- issue_pc  out  32*NSLOT  per-slot PC.
- issue_cnt  out  3  instructions issued this cycle.
- q_count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0 at posedge): head, tail and count go to 0; load-use tracker cleared. Outputs: issue_valid=0, issue_instr=0, issue_pc=0, issue_cnt=0, fetch_ready=1.
- Classification, by opcode [31:26]:
  - 000000: ALU; srcs rs, rt; dest rd.
  - 001xxx: ALU; src rs; dest rt.
  - 100011: load; src rs; dest rt.
  - 101011: store; srcs rs, rt; no dest.
  - 000100/000101: branch; srcs rs, rt; no dest.
  - Other opcodes: ALU with no sources or dest.
  - Register 0 is never a source or dest for hazard purposes.
- Push is all-or-nothing. fetch_ready = (DEPTH - count) >= FETCH_W, computed from registered count only; issues in the same cycle are not credited. Accept occurs when fetch_valid & fetch_ready & ~flush. Pointers wrap modulo DEPTH.
- Issue selection, combinational over entries head..head+MAX_ISSUE-1. Take entries in order and stop at the first entry that meets any of:
  - not present (beyond count);
  - its class slot is exhausted (ALU/branch share NUM_ALU slots; one load; one store);
  - a source equals the dest of an older entry already selected (RAW);
  - its dest equals the dest of an older selected entry (WAW);
  - a source equals the tracked dest of a load issued in the previous cycle (load-use);
  - an older selected entry is a branch. A branch always closes the group; no issue past a branch.
- Slot mapping: selected ALU/branch entries take ALU slots 0,1,... in program order. The load and store take their fixed slots.
- Output timing: outputs are registered, so an entry at head is issued on the following cycle edge. At each posedge with ~exec_stall, the selected set is written to the outputs, head advances by issue_cnt, and the load tracker is set to the issued load's dest (cleared if no load issued).
- exec_stall=1:
  - Outputs, head and tracker hold.
  - Push continues.
  - The tracker still blocks a dependent instruction from issuing on the first unstalled cycle.
- flush=1 (priority over push, issue and stall): head=tail=count=0, issue_valid=0, issue_cnt=0, tracker cleared, on the same edge. A fetch group presented that cycle is dropped.
- Occupancy update: count_next = count + (push ? FETCH_W : 0) - issued. Count never underflows or overflows by construction.
- Empty queue: issue_valid=0 and issue_cnt=0 on the next edge (when unstalled).
- Full queue: fetch_ready=0.
- Reset mid-operation discards all state identically to flush.

Decomposition:
- Shared package (dispatch_pkg):
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_IMM prefix);
  - class enum (CLS_ALU, CLS_BR, CLS_LD, CLS_ST);
  - struct of {cls, src1, src1_v, src2, src2_v, dest, dest_v}.
- One natural sub-module: instr_classify. It is combinational, instantiated once per examined entry, and maps an instruction to the struct above.

Test Plan:
- Reset, then push {add r1,r2,r3; lw r4,0(r5); sw r6,4(r7); sub r8,r9,r10} with no hazards → next cycle: slots ALU0=add, ALU1=sub, LD=lw, ST=sw; issue_cnt=4; q_count=0.
- Push {add r1,r2,r3; add r4,r1,r5; ...} → cycle 1 issues only the first add (issue_cnt=1); the dependent add issues the following cycle.
- Push {lw r2,0(r1); lw r3,0(r1)} → one load per cycle (issue_cnt=1, then 1). Next, lw r2 followed by add r4,r2,r2 in the next group → the add is held one extra cycle by load-use.
- Push {beq r1,r2,L; add r3,r4,r5} → only the beq issues (ALU0, issue_cnt=1); the add issues next cycle.
- Fill to DEPTH=8 with exec_stall=1 → fetch_ready=0 at q_count=8. Then assert flush → next cycle q_count=0, issue_valid=0, fetch_ready=1.
- Assert exec_stall while outputs are valid → issue_valid, issue_instr and issue_pc hold unchanged for 3 stalled cycles; head does not advance.

Source files
------------

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the dispatch window.
//   Opcode constants, the execution class enum, and the decoded-entry struct
//   produced by instr_classify and consumed by the issue selector.
package dispatch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [2:0] OP_IMM   = 3'b001;    // prefix of opcode[5:3]

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_BR  = 2'd1,
    CLS_LD  = 2'd2,
    CLS_ST  = 2'd3
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [4:0] src1;
    logic       src1_v;
    logic [4:0] src2;
    logic       src2_v;
    logic [4:0] dest;
    logic       dest_v;
  } dec_t;

  // r0 is hardwired, so it never creates a dependency.
  function automatic logic reg_live(input logic [4:0] r);
    return r != 5'd0;
  endfunction

endpackage

// File: rtl/dispatch_window_classify.sv
// instr_classify: combinational decode of one instruction into its issue
// class plus source/destination registers used for hazard checks.
//   instr : 32-bit instruction word
//   dec   : decoded class, sources, destination (valid bits exclude r0)
module instr_classify
  import dispatch_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [4:0] rs, rt, rd;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  always_comb begin
    dec     = '0;
    dec.cls = CLS_ALU;
    if (op == OP_RTYPE) begin
      dec.src1 = rs; dec.src1_v = reg_live(rs);
      dec.src2 = rt; dec.src2_v = reg_live(rt);
      dec.dest = rd; dec.dest_v = reg_live(rd);
    end else if (op[5:3] == OP_IMM) begin
      dec.src1 = rs; dec.src1_v = reg_live(rs);
      dec.dest = rt; dec.dest_v = reg_live(rt);
    end else if (op == OP_LW) begin
      dec.cls  = CLS_LD;
      dec.src1 = rs; dec.src1_v = reg_live(rs);
      dec.dest = rt; dec.dest_v = reg_live(rt);
    end else if (op == OP_SW) begin
      dec.cls  = CLS_ST;
      dec.src1 = rs; dec.src1_v = reg_live(rs);
      dec.src2 = rt; dec.src2_v = reg_live(rt);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      dec.cls  = CLS_BR;
      dec.src1 = rs; dec.src1_v = reg_live(rs);
      dec.src2 = rt; dec.src2_v = reg_live(rt);
    end
    // anything else: ALU class with no register operands
  end

endmodule

// File: rtl/dispatch_window.sv
// dispatch_window: circular instruction queue between fetch and register read.
//   Accepts whole fetch groups, classifies the oldest MAX_ISSUE entries and
//   issues the longest hazard-free in-order prefix into typed slots.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   fetch_valid/instr/pc   incoming group (lane 0 oldest, PC of lane 0)
//   fetch_ready            room for a whole group (registered count only)
//   flush                  discard everything, highest priority
//   exec_stall             hold issue outputs, head and load tracker
//   issue_valid/instr/pc   per-slot outputs: ALU0..ALU{NUM_ALU-1}, LD, ST
//   issue_cnt              instructions issued this cycle
//   q_count                queue occupancy
module dispatch_window
  import dispatch_pkg::*;
#(
  parameter int FETCH_W   = 4,
  parameter int DEPTH     = 8,
  parameter int NUM_ALU   = 2,
  parameter int MAX_ISSUE = 4,
  localparam int NSLOT    = NUM_ALU + 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fetch_valid,
  input  logic [FETCH_W-1:0][31:0]       fetch_instr,
  input  logic [31:0]                    fetch_pc,
  output logic                           fetch_ready,
  input  logic                           flush,
  input  logic                           exec_stall,
  output logic [NSLOT-1:0]               issue_valid,
  output logic [NSLOT-1:0][31:0]         issue_instr,
  output logic [NSLOT-1:0][31:0]         issue_pc,
  output logic [2:0]                     issue_cnt,
  output logic [CW-1:0]                  q_count
);

  localparam int SW    = $clog2(NSLOT);
  localparam int LD_SL = NUM_ALU;
  localparam int ST_SL = NUM_ALU + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [4:0]    trk_dest;
  logic          trk_v;
  logic          push;

  assign q_count     = count;
  assign fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_W);
  assign push        = fetch_valid & fetch_ready & ~flush;

  // ---- decode of the issue window ----
  logic [AW-1:0] idx [MAX_ISSUE];
  dec_t          dec [MAX_ISSUE];

  for (genvar k = 0; k < MAX_ISSUE; k++) begin : g_win
    assign idx[k] = head + AW'(k);
    instr_classify u_cls (.instr(instr_q[idx[k]]), .dec(dec[k]));
  end

  // ---- in-order prefix selection ----
  logic [NSLOT-1:0]       sel_valid;
  logic [NSLOT-1:0][31:0] sel_instr, sel_pc;
  logic [2:0]             sel_cnt;
  logic [4:0]             sel_ld_dest;
  logic                   sel_ld_v;
  logic                   stop, ld_used, st_used, slot_ok, hazard;
  logic [SW-1:0]          n_alu;
  logic [31:0]            dest_mask;  // dests of entries selected so far

  always_comb begin
    sel_valid   = '0;
    sel_instr   = '0;
    sel_pc      = '0;
    sel_cnt     = '0;
    sel_ld_dest = '0;
    sel_ld_v    = 1'b0;
    stop        = 1'b0;
    ld_used     = 1'b0;
    st_used     = 1'b0;
    n_alu       = '0;
    dest_mask   = '0;
    slot_ok     = 1'b0;
    hazard      = 1'b0;
    for (int k = 0; k < MAX_ISSUE; k++) begin
      case (dec[k].cls)
        CLS_LD:  slot_ok = !ld_used;
        CLS_ST:  slot_ok = !st_used;
        default: slot_ok = n_alu < SW'(NUM_ALU);
      endcase
      // RAW against selected older entries, load-use against last cycle's
      // load, WAW against selected older entries.
      hazard = (dec[k].src1_v && (dest_mask[dec[k].src1] ||
                                  (trk_v && dec[k].src1 == trk_dest))) ||
               (dec[k].src2_v && (dest_mask[dec[k].src2] ||
                                  (trk_v && dec[k].src2 == trk_dest))) ||
               (dec[k].dest_v && dest_mask[dec[k].dest]);
      if (!stop && k < int'(count) && slot_ok && !hazard) begin
        case (dec[k].cls)
          CLS_LD: begin
            sel_valid[LD_SL] = 1'b1;
            sel_instr[LD_SL] = instr_q[idx[k]];
            sel_pc[LD_SL]    = pc_q[idx[k]];
            ld_used          = 1'b1;
            sel_ld_dest      = dec[k].dest;
            sel_ld_v         = dec[k].dest_v;
          end
          CLS_ST: begin
            sel_valid[ST_SL] = 1'b1;
            sel_instr[ST_SL] = instr_q[idx[k]];
            sel_pc[ST_SL]    = pc_q[idx[k]];
            st_used          = 1'b1;
          end
          default: begin
            sel_valid[n_alu] = 1'b1;
            sel_instr[n_alu] = instr_q[idx[k]];
            sel_pc[n_alu]    = pc_q[idx[k]];
            n_alu            = n_alu + SW'(1);
          end
        endcase
        if (dec[k].dest_v) dest_mask[dec[k].dest] = 1'b1;
        if (dec[k].cls == CLS_BR) stop = 1'b1;  // branch closes the group
        sel_cnt = sel_cnt + 3'd1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // ---- queue storage (no reset needed; pointers gate visibility) ----
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_W; i++) begin
        instr_q[tail + AW'(i)] <= fetch_instr[i];
        pc_q[tail + AW'(i)]    <= fetch_pc + 32'(4 * i);
      end
    end
  end

  // ---- pointers, occupancy, tracker, registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      trk_dest    <= '0;
      trk_v       <= 1'b0;
      issue_valid <= '0;
      issue_instr <= '0;
      issue_pc    <= '0;
      issue_cnt   <= '0;
    end else begin
      if (push) tail <= tail + AW'(FETCH_W);
      count <= count + (push ? CW'(FETCH_W) : '0)
                     - (exec_stall ? '0 : CW'(sel_cnt));
      if (!exec_stall) begin
        issue_valid <= sel_valid;
        issue_instr <= sel_instr;
        issue_pc    <= sel_pc;
        issue_cnt   <= sel_cnt;
        head        <= head + AW'(sel_cnt);
        trk_dest    <= sel_ld_dest;
        trk_v       <= sel_ld_v;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_window.sv
// Scoreboard bench for dispatch_window: a queue-based reference model predicts
// the outputs after each edge; a negedge monitor pops and compares.
module tb_dispatch_window;

  localparam int FETCH_W = 4, DEPTH = 8, NUM_ALU = 2, MAX_ISSUE = 4;
  localparam int NSLOT = NUM_ALU + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, fetch_valid, fetch_ready, flush, exec_stall;
  logic [FETCH_W-1:0][31:0] fetch_instr;
  logic [31:0]              fetch_pc;
  logic [NSLOT-1:0]         issue_valid;
  logic [NSLOT-1:0][31:0]   issue_instr, issue_pc;
  logic [2:0]               issue_cnt;
  logic [CW-1:0]            q_count;

  dispatch_window #(.FETCH_W(FETCH_W), .DEPTH(DEPTH), .NUM_ALU(NUM_ALU),
                    .MAX_ISSUE(MAX_ISSUE)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .flush(flush), .exec_stall(exec_stall), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_cnt(issue_cnt),
    .q_count(q_count));

  typedef struct {
    logic [NSLOT-1:0]       v;
    logic [NSLOT-1:0][31:0] ins;
    logic [NSLOT-1:0][31:0] pc;
    int                     cnt;
    int                     qc;
    bit                     fr;
    bit                     all;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  exp_t exp_q[$];
  ent_t mq[$];
  int   trk = -1;
  logic [NSLOT-1:0]       mo_v   = '0;
  logic [NSLOT-1:0][31:0] mo_ins = '0;
  logic [NSLOT-1:0][31:0] mo_pc  = '0;
  int   mo_cnt = 0;
  int   vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // cls: 0 alu, 1 branch, 2 load, 3 store; register -1 means none
  function automatic void decode(input logic [31:0] w, output int cls,
                                 output int s1, output int s2, output int d);
    int op = int'(w[31:26]);
    int rs = int'(w[25:21]), rt = int'(w[20:16]), rd = int'(w[15:11]);
    cls = 0; s1 = -1; s2 = -1; d = -1;
    if (op == 0) begin s1 = rs; s2 = rt; d = rd; end
    else if (op >= 8 && op <= 15) begin s1 = rs; d = rt; end
    else if (op == 35) begin cls = 2; s1 = rs; d = rt; end
    else if (op == 43) begin cls = 3; s1 = rs; s2 = rt; end
    else if (op == 4 || op == 5) begin cls = 1; s1 = rs; s2 = rt; end
    if (s1 == 0) s1 = -1;
    if (s2 == 0) s2 = -1;
    if (d == 0) d = -1;
  endfunction

  function automatic logic [31:0] rtype(int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] itype(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rnd_instr();
    int r1 = int'($urandom_range(0, 7)), r2 = int'($urandom_range(0, 7));
    int r3 = int'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0, 1: return rtype(r1, r2, r3);
      2:    return itype(8 + int'($urandom_range(0, 7)), r1, r2, 5);
      3:    return itype(35, r1, r2, 4);
      4:    return itype(43, r1, r2, 8);
      5:    return itype(4, r1, r2, 16);
      6:    return itype(5, r1, r2, 16);
      default: return itype(2, r1, r2, 0);  // jump-like: no operands
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge,
  // and hand the predicted post-edge outputs to the monitor.
  task automatic step(input bit fv, input logic [FETCH_W-1:0][31:0] grp,
                      input logic [31:0] pc, input bit fl, input bit st,
                      input bit rs);
    exp_t e;
    bit   ready = (DEPTH - mq.size()) >= FETCH_W;
    rst_n = rs; fetch_valid = fv; fetch_instr = grp; fetch_pc = pc;
    flush = fl; exec_stall = st;
    e.all = 1'b0;
    if (!rs || fl) begin
      mq.delete(); trk = -1;
      mo_v = '0; mo_ins = '0; mo_pc = '0; mo_cnt = 0;
      e.all = !rs;
    end else begin
      if (!st) begin
        int  nalu = 0, n = 0, ldd = -1;
        bit  ldu = 0, stu = 0;
        bit  used[32];
        logic [NSLOT-1:0]       v = '0;
        logic [NSLOT-1:0][31:0] ins = '0, pcs = '0;
        foreach (used[r]) used[r] = 1'b0;
        for (int k = 0; k < MAX_ISSUE && k < mq.size(); k++) begin
          int c, a, b, d, sl;
          bit ok;
          decode(mq[k].ins, c, a, b, d);
          ok = (c <= 1) ? (nalu < NUM_ALU) : (c == 2) ? !ldu : !stu;
          if (a >= 0 && (used[a] || a == trk)) ok = 0;
          if (b >= 0 && (used[b] || b == trk)) ok = 0;
          if (d >= 0 && used[d]) ok = 0;
          if (!ok) break;
          if (c <= 1) begin sl = nalu; nalu++; end
          else if (c == 2) begin sl = NUM_ALU; ldu = 1; ldd = d; end
          else begin sl = NUM_ALU + 1; stu = 1; end
          v[sl] = 1'b1; ins[sl] = mq[k].ins; pcs[sl] = mq[k].pc;
          if (d >= 0) used[d] = 1'b1;
          n++;
          if (c == 1) break;
        end
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        mo_v = v; mo_ins = ins; mo_pc = pcs; mo_cnt = n; trk = ldd;
      end
      if (fv && ready)
        for (int i = 0; i < FETCH_W; i++) mq.push_back('{grp[i], pc + 32'(4 * i)});
    end
    e.v = mo_v; e.ins = mo_ins; e.pc = mo_pc; e.cnt = mo_cnt;
    e.qc = mq.size(); e.fr = (DEPTH - mq.size()) >= FETCH_W;
    @(posedge clk);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic idle(input int n, input bit st = 0);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, st, 1);
  endtask

  // monitor: compare DUT against the oldest prediction mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_valid", 64'(issue_valid), 64'(e.v));
        check("issue_cnt", 64'(issue_cnt), 64'(e.cnt));
        check("q_count", 64'(q_count), 64'(e.qc));
        check("fetch_ready", 64'(fetch_ready), 64'(e.fr));
        for (int s = 0; s < NSLOT; s++)
          if (e.all || e.v[s]) begin
            check($sformatf("issue_instr%0d", s), 64'(issue_instr[s]), 64'(e.ins[s]));
            check($sformatf("issue_pc%0d", s), 64'(issue_pc[s]), 64'(e.pc[s]));
          end
      end
    end
  end

  initial begin
    logic [FETCH_W-1:0][31:0] g;
    rst_n = 0; fetch_valid = 0; fetch_instr = '0; fetch_pc = '0;
    flush = 0; exec_stall = 0;
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);

    // independent add/lw/sw/sub fill every slot in one cycle
    g[0] = rtype(1, 2, 3); g[1] = itype(35, 4, 5, 0);
    g[2] = itype(43, 6, 7, 4); g[3] = rtype(8, 9, 10);
    step(1, g, 32'h100, 0, 0, 1);
    idle(1);
    check("t1_cnt", 64'(issue_cnt), 64'd4);
    check("t1_valid", 64'(issue_valid), 64'hf);
    check("t1_qcount", 64'(q_count), 64'd0);
    check("t1_ld_pc", 64'(issue_pc[NUM_ALU]), 64'h104);

    // RAW inside a group
    g[0] = rtype(1, 2, 3); g[1] = rtype(4, 1, 5);
    g[2] = rtype(6, 7, 11); g[3] = rtype(9, 10, 12);
    step(1, g, 32'h200, 0, 0, 1);
    idle(1);
    check("t2_cnt", 64'(issue_cnt), 64'd1);
    idle(2);

    // two loads, then load-use across groups
    g[0] = itype(35, 2, 1, 0); g[1] = itype(35, 3, 1, 4);
    g[2] = itype(43, 7, 6, 0); g[3] = rtype(13, 14, 15);
    step(1, g, 32'h300, 0, 0, 1);
    idle(1);
    check("t3_cnt", 64'(issue_cnt), 64'd1);
    idle(2);
    g[0] = itype(35, 2, 1, 0); g[1] = itype(43, 9, 8, 0);
    g[2] = rtype(16, 17, 18); g[3] = rtype(19, 20, 21);
    step(1, g, 32'h400, 0, 0, 1);
    g[0] = rtype(4, 2, 2); g[1] = rtype(22, 23, 24);
    g[2] = rtype(25, 26, 27); g[3] = rtype(28, 29, 30);
    step(1, g, 32'h410, 0, 0, 1);
    idle(4);

    // branch closes the group
    g[0] = itype(4, 2, 1, 8); g[1] = rtype(3, 4, 5);
    g[2] = rtype(6, 7, 8); g[3] = rtype(9, 10, 11);
    step(1, g, 32'h500, 0, 0, 1);
    idle(1);
    check("t4_cnt", 64'(issue_cnt), 64'd1);
    check("t4_valid", 64'(issue_valid), 64'h1);
    idle(3);

    // fill under stall, then flush with a group on the port
    step(1, g, 32'h600, 0, 1, 1);
    step(1, g, 32'h610, 0, 1, 1);
    check("t5_full_ready", 64'(fetch_ready), 64'd0);
    check("t5_full_count", 64'(q_count), 64'd8);
    step(1, g, 32'h620, 1, 0, 1);
    check("t5_flush_count", 64'(q_count), 64'd0);
    check("t5_flush_valid", 64'(issue_valid), 64'd0);
    check("t5_flush_ready", 64'(fetch_ready), 64'd1);

    // stall while outputs valid
    g[0] = rtype(1, 2, 3); g[1] = itype(35, 4, 5, 0);
    g[2] = itype(43, 6, 7, 4); g[3] = rtype(8, 9, 10);
    step(1, g, 32'h700, 0, 0, 1);
    step(1, g, 32'h710, 0, 0, 1);
    idle(3, 1);
    idle(3);

    // randomized traffic including flush, stall and reset
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < FETCH_W; i++) g[i] = rnd_instr();
      step($urandom_range(0, 9) < 7, g, {$urandom_range(0, 4095), 4'h0},
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25,
           !($urandom_range(0, 199) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
